// File: rtl/dbg_monitor_pkg.sv
// Shared encodings and glyph constants for the debug display reader.
package dbg_monitor_pkg;

  typedef enum logic [1:0] {
    DBG_MODE_SYS = 2'd0,
    DBG_MODE_PC  = 2'd1,
    DBG_MODE_RF  = 2'd2,
    DBG_MODE_DM  = 2'd3
  } dbg_mode_e;

  localparam int unsigned DBG_ST_BIT = 2;

  typedef enum logic [DBG_ST_BIT-1:0] {
    DBG_ST_IDLE    = 2'd0,
    DBG_ST_SETTLE  = 2'd1,
    DBG_ST_CAPTURE = 2'd2
  } dbg_state_e;

  // Active-high segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] GLYPH_0 = 7'h3F;
  localparam logic [6:0] GLYPH_1 = 7'h06;
  localparam logic [6:0] GLYPH_2 = 7'h5B;
  localparam logic [6:0] GLYPH_3 = 7'h4F;
  localparam logic [6:0] GLYPH_4 = 7'h66;
  localparam logic [6:0] GLYPH_5 = 7'h6D;
  localparam logic [6:0] GLYPH_6 = 7'h7D;
  localparam logic [6:0] GLYPH_7 = 7'h07;
  localparam logic [6:0] GLYPH_8 = 7'h7F;
  localparam logic [6:0] GLYPH_9 = 7'h6F;
  localparam logic [6:0] GLYPH_A = 7'h77;
  localparam logic [6:0] GLYPH_B = 7'h7C;
  localparam logic [6:0] GLYPH_C = 7'h39;
  localparam logic [6:0] GLYPH_D = 7'h5E;
  localparam logic [6:0] GLYPH_E = 7'h79;
  localparam logic [6:0] GLYPH_F = 7'h71;

endpackage

// File: rtl/dbg_monitor_btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stability counter, rising-edge pulse.
module dbg_monitor_btn_debounce #(
  parameter int unsigned DebounceCycles = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int unsigned CntW = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

  logic [1:0]      sync_q;
  logic            stable_q, stable_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pulse_q, pulse_d;

  // Accept a new level only after DebounceCycles consecutive differing samples.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    pulse_d  = 1'b0;
    if (sync_q[1] != stable_q) begin
      if (cnt_q == CntLast) begin
        stable_d = sync_q[1];
        pulse_d  = sync_q[1];
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // Synchronizer and debounce state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= 2'b00;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      sync_q   <= {sync_q[0], btn_i};
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/dbg_monitor.sv
// Board-side debug reader: index navigation, per-frame capture, 8-digit hex scan.
// Optional autoscan while halted is enabled by defining DBG_MON_AUTOSCAN_EN.
module dbg_monitor
  import dbg_monitor_pkg::*;
#(
  parameter int unsigned ScanDiv        = 50000,
  parameter int unsigned DebounceCycles = 500000,
  parameter int unsigned DmAddrBit      = 10,
  parameter int unsigned SettleCycles   = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 btn_next,
  input  logic                 btn_prev,
  input  logic [1:0]           mode,
  input  logic                 cpu_halted,
  input  logic [31:0]          pc_dbg,
  input  logic [31:0]          display_in,
  input  logic [31:0]          regfile_data_dbg,
  input  logic [31:0]          datamem_data_dbg,
  output logic [4:0]           regfile_req_dbg,
  output logic [DmAddrBit-1:0] datamem_addr_dbg,
  output logic [7:0]           seg_n,
  output logic [7:0]           an_n
);

  localparam int unsigned ScanW = (ScanDiv > 1) ? $clog2(ScanDiv) : 1;
  localparam int unsigned SetW  = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;
  localparam logic [ScanW-1:0] ScanLast   = ScanW'(ScanDiv - 1);
  localparam logic [SetW-1:0]  SettleLoad = SetW'(SettleCycles - 1);

  function automatic logic [6:0] hex_seg_n(input logic [3:0] nib);
    logic [6:0] g;
    unique case (nib)
      4'h0: g = GLYPH_0;  4'h1: g = GLYPH_1;  4'h2: g = GLYPH_2;  4'h3: g = GLYPH_3;
      4'h4: g = GLYPH_4;  4'h5: g = GLYPH_5;  4'h6: g = GLYPH_6;  4'h7: g = GLYPH_7;
      4'h8: g = GLYPH_8;  4'h9: g = GLYPH_9;  4'hA: g = GLYPH_A;  4'hB: g = GLYPH_B;
      4'hC: g = GLYPH_C;  4'hD: g = GLYPH_D;  4'hE: g = GLYPH_E;  4'hF: g = GLYPH_F;
    endcase
    return ~g;
  endfunction

  dbg_mode_e mode_cur, mode_q;
  logic      next_p, prev_p;
  logic      step_up, step_dn;

  logic [4:0]           reg_idx_q, reg_idx_d;
  logic [DmAddrBit-1:0] mem_idx_q, mem_idx_d;

  dbg_state_e      state_q, state_d;
  logic [SetW-1:0] settle_q, settle_d;
  logic [31:0]     value_q, value_d, sel_val;

  logic [ScanW-1:0] presc_q, presc_d;
  logic [2:0]       digit_q, digit_d;
  logic [7:0]       an_q, an_d, seg_q, seg_d;
  logic             tick, frame_start, idx_chg, trig;

  assign mode_cur    = dbg_mode_e'(mode);
  assign tick        = (presc_q == ScanLast);
  // The digit counter wraps to slot 0 here, so the new value lands before slot 0 is drawn.
  assign frame_start = tick && (digit_q == 3'd7);

  dbg_monitor_btn_debounce #(.DebounceCycles(DebounceCycles)) u_btn_next (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_next), .pulse_o(next_p)
  );
  dbg_monitor_btn_debounce #(.DebounceCycles(DebounceCycles)) u_btn_prev (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_prev), .pulse_o(prev_p)
  );

`ifdef DBG_MON_AUTOSCAN_EN
  logic [2:0] frame_cnt_q, frame_cnt_d;
  logic       scan_active;
  assign scan_active = cpu_halted && ((mode_cur == DBG_MODE_RF) || (mode_cur == DBG_MODE_DM));
`endif

  // Index navigation; simultaneous presses cancel, inactive modes ignore pulses.
  always_comb begin
    reg_idx_d = reg_idx_q;
    mem_idx_d = mem_idx_q;
    step_up   = next_p & ~prev_p;
    step_dn   = prev_p & ~next_p;
`ifdef DBG_MON_AUTOSCAN_EN
    frame_cnt_d = frame_cnt_q;
    if (next_p | prev_p) begin
      frame_cnt_d = 3'd0;
    end else if (scan_active && frame_start) begin
      frame_cnt_d = frame_cnt_q + 3'd1;
      if (frame_cnt_q == 3'd7) step_up = 1'b1;
    end
`endif
    if (mode_cur == DBG_MODE_RF) begin
      if (step_up)      reg_idx_d = reg_idx_q + 5'd1;
      else if (step_dn) reg_idx_d = reg_idx_q - 5'd1;
    end else if (mode_cur == DBG_MODE_DM) begin
      if (step_up)      mem_idx_d = mem_idx_q + DmAddrBit'(1);
      else if (step_dn) mem_idx_d = mem_idx_q - DmAddrBit'(1);
    end
  end

  assign idx_chg = (reg_idx_d != reg_idx_q) || (mem_idx_d != mem_idx_q) || (mode_cur != mode_q);
  assign trig    = idx_chg || frame_start;

  // Source select for capture.
  always_comb begin
    sel_val = display_in;
    unique case (mode_cur)
      DBG_MODE_SYS: sel_val = display_in;
      DBG_MODE_PC:  sel_val = pc_dbg;
      DBG_MODE_RF:  sel_val = regfile_data_dbg;
      DBG_MODE_DM:  sel_val = datamem_data_dbg;
    endcase
  end

  // Capture FSM: wait for read data to settle after any request change, then latch once.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    value_d  = value_q;
    unique case (state_q)
      DBG_ST_IDLE: begin
        if (trig) begin
          state_d  = DBG_ST_SETTLE;
          settle_d = SettleLoad;
        end
      end
      DBG_ST_SETTLE: begin
        if (idx_chg)                settle_d = SettleLoad;
        else if (settle_q == '0)    state_d  = DBG_ST_CAPTURE;
        else                        settle_d = settle_q - SetW'(1);
      end
      DBG_ST_CAPTURE: begin
        value_d = sel_val;
        if (trig) begin
          state_d  = DBG_ST_SETTLE;
          settle_d = SettleLoad;
        end else begin
          state_d = DBG_ST_IDLE;
        end
      end
      default: state_d = DBG_ST_IDLE;
    endcase
  end

  // Digit scan: anode and segments are registered together on each tick.
  always_comb begin
    presc_d = tick ? '0 : presc_q + ScanW'(1);
    digit_d = digit_q;
    an_d    = an_q;
    seg_d   = seg_q;
    if (tick) begin
      digit_d = digit_q + 3'd1;
      an_d    = ~(8'h01 << digit_q);
      seg_d   = {~(cpu_halted && (digit_q == 3'd7)), hex_seg_n(value_q[{digit_q, 2'b00} +: 4])};
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= DBG_MODE_SYS;
      reg_idx_q <= '0;
      mem_idx_q <= '0;
      state_q   <= DBG_ST_IDLE;
      settle_q  <= '0;
      value_q   <= '0;
      presc_q   <= '0;
      digit_q   <= '0;
      an_q      <= 8'hFF;
      seg_q     <= 8'hFF;
`ifdef DBG_MON_AUTOSCAN_EN
      frame_cnt_q <= 3'd0;
`endif
    end else begin
      mode_q    <= mode_cur;
      reg_idx_q <= reg_idx_d;
      mem_idx_q <= mem_idx_d;
      state_q   <= state_d;
      settle_q  <= settle_d;
      value_q   <= value_d;
      presc_q   <= presc_d;
      digit_q   <= digit_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
`ifdef DBG_MON_AUTOSCAN_EN
      frame_cnt_q <= frame_cnt_d;
`endif
    end
  end

  assign regfile_req_dbg  = reg_idx_q;
  assign datamem_addr_dbg = mem_idx_q;
  assign an_n             = an_q;
  assign seg_n            = seg_q;

endmodule

// File: doc/dbg_monitor.md
Name: dbg_monitor

Overview:
- Board-side debug reader for the pipelined CPU's debug interface.
- Drives the CPU's debug request ports (register index, data-memory address) and reads back the returned debug data.
- Shows the selected 32-bit value as 8 hex digits on a time-multiplexed, active-low seven-segment display.
- Sits at board top, beside the CPU core; user navigates with two push buttons and a mode switch.

Parameters:
- ScanDiv, 50000, clk cycles per display digit slot (>=2).
- DebounceCycles, 500000, consecutive stable cycles before a button change is accepted (>=2).
- DmAddrBit, 10, width of the data-memory debug address; matches `DM_ADDR_BIT.
- SettleCycles, 2, wait cycles after a debug address change before capturing read data (>=1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- btn_next  in  1  raw push button, increment index
- btn_prev  in  1  raw push button, decrement index
- mode  in  2  0=syscall display, 1=pc, 2=regfile, 3=datamem
- cpu_halted  in  1  CPU halted flag
- pc_dbg  in  32  CPU pc debug value
- display_in  in  32  CPU syscall display register
- regfile_data_dbg  in  32  register read-back
- datamem_data_dbg  in  32  memory read-back
- regfile_req_dbg  out  5  register index to CPU
- datamem_addr_dbg  out  DmAddrBit  memory address to CPU
- seg_n  out  8  segments {dp,g,f,e,d,c,b,a}, active low
- an_n  out  8  digit enables, active low, one-hot

Behaviour:
- Buttons:
  - 2-FF synchronizer, then a debounce counter. The stable level updates only after DebounceCycles identical synchronized samples.
  - A rising edge of the stable level produces a 1-cycle pulse (next_p / prev_p).
- Index registers:
  - reg_idx (5b) is active in mode 2; mem_idx (DmAddrBit) is active in mode 3. Pulses are ignored in modes 0/1.
  - next_p: +1 with wrap (31->0, all-ones->0). prev_p: -1 with wrap (0->31, 0->all-ones).
  - next_p and prev_p in the same cycle: no change.
  - Indices are retained across mode changes. The outputs are the index registers directly (registered).
- Capture FSM:
  - IDLE: on index change, mode change, or frame start (digit slot 0 begins) -> SETTLE, counter loaded with SettleCycles-1.
  - SETTLE: count down; at 0 -> CAPTURE. A new index or mode change restarts SETTLE.
  - CAPTURE: value_q <= mux(mode); -> IDLE. Exactly 1 cycle.
- value_q is what is displayed. Capturing once per frame prevents digit tearing.
- Scan:
  - Prescaler counts 0..ScanDiv-1; tick at ScanDiv-1.
  - On each tick, digit (3b) increments with wrap 7->0, and an_n and seg_n are registered together.
  - Digit d shows value_q[4d+3:4d]; digit 7 is leftmost.
  - dp is lit (bit7=0) on digit 7 iff cpu_halted; otherwise dp is off.
- Hex font: standard 0-F ('b','d' lowercase).
- Reset values: seg_n=8'hFF, an_n=8'hFF, regfile_req_dbg=0, datamem_addr_dbg=0, value_q=0, digit=0, prescaler=0, FSM=IDLE, debounced levels=0.
- First tick after reset: an_n=8'hFE, seg_n = glyph of value_q[3:0].
- Reset asserted mid-operation returns everything above to reset values immediately (asynchronously).

Optional Feature:
- Macro: DBG_MON_AUTOSCAN_EN.
- Defined: while cpu_halted=1 and mode is 2 or 3, the active index auto-increments (with wrap) once every 8 frames. Button pulses still apply, and a button pulse restarts the 8-frame count.
- Undefined: indices change only on button pulses; no autoscan logic is synthesized.

Decomposition:
- Core.vh gains:
  - mode encodings DBG_MODE_SYS/PC/RF/DM;
  - FSM state encodings DBG_ST_IDLE/SETTLE/CAPTURE and DBG_ST_BIT;
  - hex-glyph constants.
- One sub-module, btn_debounce: synchronizer + counter + edge pulse, instantiated twice.
- The hex-to-segment decoder is an internal function, not a separate module.

Test Plan:
- Reset with DebounceCycles=4, ScanDiv=4; release rst_n -> an_n 8'hFF until first tick, then 8'hFE, FD, FB, ... F7 ... 7F, back to FE; seg_n=8'hFF during reset.
- mode=2, one btn_prev press held 6 cycles -> regfile_req_dbg 0->31. Bench returns regfile_data_dbg=32'h1234ABCD -> after next frame capture, digits 7..0 show 1,2,3,4,A,b,C,d (digit 0 seg_n=8'hA1).
- 3-cycle glitch on btn_next -> no index change. btn_next and btn_prev pressed together -> no change.
- mode=3, 1025 next presses with DmAddrBit=10 -> datamem_addr_dbg=1 (wrapped). Mode to 2 and back -> index preserved.
- cpu_halted=1, mode=1, pc_dbg=32'h00000040 -> digit 7 seg_n bit7=0, digit 1 shows '4'. cpu_halted=0 -> bit7=1.
- Index change mid-SETTLE -> CAPTURE occurs SettleCycles after the last change. rst_n pulse mid-frame -> all outputs at reset values within the same cycle.
